// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcodes, funct3 codes and the fetch-stage state encoding.
package isa_pkg;

  typedef enum logic [6:0] {
    OpBranch = 7'b1100011,  // BLE plus the AES ops
    OpSha    = 7'b1101111,
    OpReg    = 7'b0110011,
    OpImm    = 7'b0010011,
    OpLoad   = 7'b0000011,
    OpStore  = 7'b0100011
  } opcode_e;

  typedef enum logic [2:0] {
    F3RAdd = 3'b000,
    F3RSll = 3'b001,
    F3RXor = 3'b100,
    F3ROr  = 3'b110,
    F3RAnd = 3'b111
  } funct3_r_e;

  typedef enum logic [2:0] {
    F3IAddi = 3'b000,
    F3IXori = 3'b100,
    F3IOri  = 3'b110,
    F3IAndi = 3'b111
  } funct3_i_e;

  // AES ops share OpBranch with BLE; BLE owns funct3 = 011.
  typedef enum logic [2:0] {
    F3AesEnc = 3'b000,
    F3AesDec = 3'b001,
    F3AesKey = 3'b010
  } funct3_aes_e;

  typedef enum logic [2:0] {
    F3Sha256 = 3'b000,
    F3Sha512 = 3'b001
  } funct3_sha_e;

  localparam logic [2:0] F3Ble = 3'b011;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StFull,
    StDiscard
  } fetch_state_e;

  function automatic logic is_legal_opcode(logic [6:0] op);
    return op inside {OpBranch, OpSha, OpReg, OpImm, OpLoad, OpStore};
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate extraction and opcode legality for a raw instruction word.
module imm_gen
  import isa_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [63:0] imm_o,
  output logic        illegal_o
);

  // Select the immediate format from the opcode; AES/SHA/R-type carry none.
  always_comb begin
    imm_o = '0;
    unique case (instr_i[6:0])
      OpImm, OpLoad: imm_o = {{52{instr_i[31]}}, instr_i[31:20]};
      OpStore:       imm_o = {{52{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      OpBranch: begin
        if (instr_i[14:12] == F3Ble) begin
          imm_o = {{51{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                   instr_i[11:8], 1'b0};
        end
      end
      default:       imm_o = '0;
    endcase
  end

  assign illegal_o = !is_legal_opcode(instr_i[6:0]);

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps one imem request in flight and
// holds the returned word in the IF/ID register until the decoder takes it.
module instr_fetch_stage
  import isa_pkg::*;
#(
  parameter int unsigned     PC_W     = 64,
  parameter int unsigned     INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [PC_W-1:0]    redirect_pc_i,
  output logic               id_valid,
  output logic [PC_W-1:0]    id_pc,
  output logic [6:0]         opCode,
  output logic [2:0]         funct3,
  output logic [6:0]         funct7,
  output logic [4:0]         rd,
  output logic [4:0]         rs1,
  output logic [4:0]         rs2,
  output logic [63:0]        imm,
  output logic               illegal_o
);

  localparam logic [PC_W-1:0] PcStep = PC_W'(4);

  fetch_state_e        state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic                id_valid_q, id_valid_d;
  logic [PC_W-1:0]     id_pc_q, id_pc_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [63:0]         imm_q, imm_d;
  logic                illegal_q, illegal_d;

  logic [63:0]         gen_imm;
  logic                gen_illegal;
  logic                latch;
  logic                release_id;
  logic                req_raw;

  imm_gen u_imm_gen (
    .instr_i   (imem_rdata),
    .imm_o     (gen_imm),
    .illegal_o (gen_illegal)
  );

  // A response is kept only if it arrives in WAIT without a simultaneous redirect.
  assign latch      = (state_q == StWait) && imem_rvalid && !redirect_i;
  // Held instruction leaves the register when consumed or flushed by a redirect.
  assign release_id = (state_q == StFull) && (redirect_i || !stall_i);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; redirect always wins over consumption or a returning response.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!redirect_i) state_d = StWait;
      end
      StWait: begin
        if (redirect_i)       state_d = imem_rvalid ? StIdle : StDiscard;
        else if (imem_rvalid) state_d = StFull;
      end
      StFull: begin
        if (redirect_i)    state_d = StIdle;
        else if (!stall_i) state_d = StWait;
      end
      StDiscard: begin
        if (imem_rvalid) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Request generation; FULL refetches in the same cycle its instruction is consumed.
  always_comb begin
    req_raw = 1'b0;
    unique case (state_q)
      StIdle:  req_raw = !redirect_i;
      StFull:  req_raw = !redirect_i && !stall_i;
      default: req_raw = 1'b0;
    endcase
  end

  assign imem_req  = req_raw & rst_n;
  assign imem_addr = pc_q;

  // PC and IF/ID next-state.
  always_comb begin
    pc_d       = pc_q;
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    instr_d    = instr_q;
    imm_d      = imm_q;
    illegal_d  = illegal_q;

    if (redirect_i) begin
      pc_d = redirect_pc_i;
    end else if (latch) begin
      pc_d = pc_q + PcStep;
    end

    if (latch) begin
      id_valid_d = 1'b1;
      id_pc_d    = pc_q;
      instr_d    = imem_rdata;
      imm_d      = gen_imm;
      illegal_d  = gen_illegal;
    end else if (release_id) begin
      id_valid_d = 1'b0;
    end
  end

  // PC and IF/ID registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      instr_q    <= '0;
      imm_q      <= '0;
      illegal_q  <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      instr_q    <= instr_d;
      imm_q      <= imm_d;
      illegal_q  <= illegal_d;
    end
  end

  assign id_valid  = id_valid_q;
  assign id_pc     = id_pc_q;
  assign opCode    = instr_q[6:0];
  assign rd        = instr_q[11:7];
  assign funct3    = instr_q[14:12];
  assign rs1       = instr_q[19:15];
  assign rs2       = instr_q[24:20];
  assign funct7    = instr_q[31:25];
  assign imm       = imm_q;
  assign illegal_o = illegal_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: directed scenarios plus random
// stall/redirect traffic against a transaction-level fetch model.
module tb_instr_fetch_stage;

  localparam logic [63:0] WrapPc = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam logic [31:0] WAddi  = 32'h00A0_0093;
  localparam logic [31:0] WLoad  = 32'hFFF0_A103;
  localparam logic [31:0] WBle   = 32'h8020_B463;
  localparam logic [31:0] WAes   = 32'h0020_8063;
  localparam logic [31:0] WIll   = 32'h0000_007F;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (RESET_PC = 0)
  logic        rst_n = 1'b0;
  logic        imem_req, imem_rvalid, stall_i, redirect_i, id_valid, illegal;
  logic [63:0] imem_addr, redirect_pc_i, id_pc, imm;
  logic [31:0] imem_rdata;
  logic [6:0]  op_code, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;

  instr_fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .id_valid      (id_valid),
    .id_pc         (id_pc),
    .opCode        (op_code),
    .funct3        (funct3),
    .funct7        (funct7),
    .rd            (rd),
    .rs1           (rs1),
    .rs2           (rs2),
    .imm           (imm),
    .illegal_o     (illegal)
  );

  // Second DUT starting near the top of the address space
  logic        w_rst_n = 1'b0;
  logic        w_req, w_rvalid, w_id_valid, w_illegal;
  logic [63:0] w_addr, w_id_pc, w_imm;
  logic [6:0]  w_op, w_f7;
  logic [2:0]  w_f3;
  logic [4:0]  w_rd, w_rs1, w_rs2;

  instr_fetch_stage #(.RESET_PC(WrapPc)) dut_w (
    .clk           (clk),
    .rst_n         (w_rst_n),
    .imem_req      (w_req),
    .imem_addr     (w_addr),
    .imem_rvalid   (w_rvalid),
    .imem_rdata    (WAddi),
    .stall_i       (1'b0),
    .redirect_i    (1'b0),
    .redirect_pc_i (64'h0),
    .id_valid      (w_id_valid),
    .id_pc         (w_id_pc),
    .opCode        (w_op),
    .funct3        (w_f3),
    .funct7        (w_f7),
    .rd            (w_rd),
    .rs1           (w_rs1),
    .rs2           (w_rs2),
    .imm           (w_imm),
    .illegal_o     (w_illegal)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  // Reference decode, straight from the immediate-format rules with integer arithmetic.
  function automatic logic [63:0] ref_imm(input logic [31:0] w);
    longint v;
    v = 0;
    if (w[6:0] == 7'h13 || w[6:0] == 7'h03) begin
      v = longint'(w[31:20]);
      if (v >= 2048) v -= 4096;
    end else if (w[6:0] == 7'h23) begin
      v = longint'(w[31:25]) * 32 + longint'(w[11:7]);
      if (v >= 2048) v -= 4096;
    end else if (w[6:0] == 7'h63 && w[14:12] == 3'd3) begin
      v = longint'(w[31]) * 4096 + longint'(w[7]) * 2048 + longint'(w[30:25]) * 32
        + longint'(w[11:8]) * 2;
      if (v >= 4096) v -= 8192;
    end
    return v;
  endfunction

  function automatic logic ref_illegal(input logic [31:0] w);
    return !(w[6:0] inside {7'h63, 7'h6F, 7'h33, 7'h13, 7'h03, 7'h23});
  endfunction

  function automatic logic [31:0] pick_word();
    logic [6:0]  ops [8];
    logic [31:0] w;
    ops = '{7'h63, 7'h6F, 7'h33, 7'h13, 7'h03, 7'h23, 7'h7F, 7'h00};
    w = $urandom;
    w[6:0] = ops[$urandom_range(0, 7)];
    if (w[6:0] == 7'h00) w[6:0] = 7'($urandom);
    if (w[6:0] == 7'h63 && $urandom_range(0, 1) == 1) w[14:12] = 3'd3;
    return w;
  endfunction

  // Model: next fetch address, the single outstanding request, and the held instruction.
  logic [63:0] m_pc;
  bit          m_out, m_killed, m_held;
  logic [63:0] m_out_addr, m_held_pc;
  logic [31:0] m_out_data, m_held_instr;
  int          m_cnt;
  bit          f_valid;
  logic [31:0] f_word;
  int          f_k;
  bit          release_rst;

  task automatic m_reset();
    m_pc = 64'h0; m_out = 0; m_killed = 0; m_held = 0; m_cnt = 0;
  endtask

  task automatic arm(input logic [31:0] w, input int k);
    f_valid = 1; f_word = w; f_k = k;
  endtask

  // One clock cycle: drive at negedge, check 1 time unit later, advance the model.
  task automatic step(input bit st, input bit rd_en, input logic [63:0] tgt);
    bit rv;
    bit req_exp;
    @(negedge clk);
    if (release_rst) begin
      rst_n = 1'b1;
      release_rst = 0;
    end
    rv = 0;
    if (m_out && m_cnt > 0) begin
      m_cnt--;
      rv = (m_cnt == 0);
    end
    stall_i = st; redirect_i = rd_en; redirect_pc_i = tgt; imem_rvalid = rv;
    imem_rdata = rv ? m_out_data : $urandom;
    #1;
    req_exp = !m_out && (!m_held || !st) && !rd_en;
    check("id_valid", {63'h0, id_valid}, {63'h0, m_held});
    if (m_held) begin
      check("id_pc", id_pc, m_held_pc);
      check("opCode", {57'h0, op_code}, {57'h0, m_held_instr[6:0]});
      check("funct3", {61'h0, funct3}, {61'h0, m_held_instr[14:12]});
      check("funct7", {57'h0, funct7}, {57'h0, m_held_instr[31:25]});
      check("rd", {59'h0, rd}, {59'h0, m_held_instr[11:7]});
      check("rs1", {59'h0, rs1}, {59'h0, m_held_instr[19:15]});
      check("rs2", {59'h0, rs2}, {59'h0, m_held_instr[24:20]});
      check("imm", imm, ref_imm(m_held_instr));
      check("illegal", {63'h0, illegal}, {63'h0, ref_illegal(m_held_instr)});
    end
    check("imem_req", {63'h0, imem_req}, {63'h0, req_exp});
    if (req_exp) check("imem_addr", imem_addr, m_pc);

    if (rd_en) begin
      m_pc = tgt;
      m_held = 0;
      if (m_out) m_killed = 1;
    end else if (m_held && !st) begin
      m_held = 0;
    end
    if (rv) begin
      m_out = 0;
      if (!m_killed) begin
        m_held = 1; m_held_pc = m_out_addr; m_held_instr = m_out_data;
        m_pc = m_out_addr + 64'd4;
      end
    end
    if (req_exp) begin
      m_out = 1; m_killed = 0; m_out_addr = m_pc;
      if (f_valid) begin
        m_out_data = f_word; m_cnt = f_k; f_valid = 0;
      end else begin
        m_out_data = pick_word(); m_cnt = $urandom_range(1, 3);
      end
    end
  endtask

  task automatic await_id(input int k);
    repeat (k) step(1, 0, 64'h0);
    step(1, 0, 64'h0);
  endtask

  bit          r_st, r_rd;
  logic [63:0] r_tgt;
  logic [63:0] w_addrs [2];
  logic [63:0] w_first_idpc;
  int          w_nreq;
  bit          w_prev, w_seen;

  initial begin
    stall_i = 0; redirect_i = 0; redirect_pc_i = '0; imem_rvalid = 0; imem_rdata = '0;
    w_rvalid = 0; f_valid = 0; release_rst = 0;
    m_reset();

    // Reset state
    @(negedge clk); #1;
    check("rst_req", {63'h0, imem_req}, 64'h0);
    check("rst_id_valid", {63'h0, id_valid}, 64'h0);
    check("rst_id_pc", id_pc, 64'h0);
    check("rst_imm", imm, 64'h0);
    release_rst = 1;

    // addi x1,x0,10 with k=1
    arm(WAddi, 1);
    step(0, 0, 64'h0);
    check("first_addr", imem_addr, 64'h0);
    await_id(1);
    check("addi_valid", {63'h0, id_valid}, 64'h1);
    check("addi_op", {57'h0, op_code}, 64'h13);
    check("addi_rd", {59'h0, rd}, 64'h1);
    check("addi_rs1", {59'h0, rs1}, 64'h0);
    check("addi_imm", imm, 64'd10);
    check("addi_pc", id_pc, 64'h0);
    check("addi_ill", {63'h0, illegal}, 64'h0);

    // Load held under a 5-cycle stall
    arm(WLoad, 1);
    step(0, 0, 64'h0);
    check("second_addr", imem_addr, 64'h4);
    await_id(1);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 64'h0);
      check("stall_req", {63'h0, imem_req}, 64'h0);
      check("stall_imm", imm, 64'hFFFF_FFFF_FFFF_FFFF);
      check("stall_pc", id_pc, 64'h4);
    end
    arm(pick_word(), 3);
    step(0, 0, 64'h0);
    check("unstall_req", {63'h0, imem_req}, 64'h1);
    check("unstall_addr", imem_addr, 64'h8);

    // Redirect in WAIT, late response discarded
    step(0, 1, 64'h100);
    step(0, 0, 64'h0);
    step(0, 0, 64'h0);
    check("discard_valid", {63'h0, id_valid}, 64'h0);
    arm(pick_word(), 2);
    step(0, 0, 64'h0);
    check("redir_addr", imem_addr, 64'h100);

    // Redirect coinciding with rvalid
    step(0, 0, 64'h0);
    step(0, 1, 64'h200);
    arm(WBle, 1);
    step(0, 0, 64'h0);
    check("same_cyc_valid", {63'h0, id_valid}, 64'h0);
    check("same_cyc_addr", imem_addr, 64'h200);

    // Immediate corner cases
    await_id(1);
    check("ble_imm", imm, 64'hFFFF_FFFF_FFFF_F008);
    arm(WAes, 1);
    step(0, 0, 64'h0);
    await_id(1);
    check("aes_imm", imm, 64'h0);
    check("aes_ill", {63'h0, illegal}, 64'h0);
    arm(WIll, 1);
    step(0, 0, 64'h0);
    await_id(1);
    check("ill_flag", {63'h0, illegal}, 64'h1);
    step(0, 0, 64'h0);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      r_st  = ($urandom_range(0, 9) < 4);
      r_rd  = ($urandom_range(0, 15) == 0);
      r_tgt = {$urandom, $urandom} & ~64'h3;
      if ($urandom_range(0, 3) == 0) r_tgt = WrapPc - 64'(4 * $urandom_range(0, 2));
      step(r_st, r_rd, r_tgt);
    end

    // Reset asserted while a request is outstanding
    arm(WAddi, 3);
    step(1, 1, 64'h40);
    step(0, 0, 64'h0);
    step(0, 0, 64'h0);
    @(negedge clk);
    rst_n = 1'b0; imem_rvalid = 0; redirect_i = 0;
    #1;
    check("midrst_valid", {63'h0, id_valid}, 64'h0);
    check("midrst_req", {63'h0, imem_req}, 64'h0);
    m_reset();
    release_rst = 1;
    arm(WAddi, 1);
    step(0, 0, 64'h0);
    check("postrst_req", {63'h0, imem_req}, 64'h1);
    check("postrst_addr", imem_addr, 64'h0);
    await_id(1);

    // PC wrap on the second instance
    w_addrs[0] = 64'h1; w_addrs[1] = 64'h1; w_first_idpc = 64'h1;
    w_nreq = 0; w_prev = 0; w_seen = 0;
    @(negedge clk);
    w_rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      w_rvalid = w_prev;
      #1;
      if (w_id_valid && !w_seen) begin
        w_first_idpc = w_id_pc;
        w_seen = 1;
      end
      if (w_req) begin
        if (w_nreq < 2) w_addrs[w_nreq] = w_addr;
        w_nreq++;
      end
      w_prev = w_req;
    end
    check("wrap_nreq", {63'h0, (w_nreq >= 2)}, 64'h1);
    check("wrap_first", w_addrs[0], WrapPc);
    check("wrap_second", w_addrs[1], 64'h0);
    check("wrap_id_pc", w_first_idpc, WrapPc);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
